// File: rtl/core_pkg.sv
// Shared pipeline types and constants for the front end.
// Fetch entries pair an instruction word with the address it was fetched from.
package core_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular fetch buffer: registered count, combinational head, flush wins over push/pop.
// Latency: push visible at dout one cycle later; push while full is legal only with a pop.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  T                           din,
  output T                           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full buffer can take a new entry only into the slot being vacated.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch.sv
// Pipeline stage 1: PC, credit-limited imem requests, response buffering, registered decode outputs.
// Response to output is 1 cycle when the buffer is empty; stall freezes outputs, redirect flushes.
module fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr_out,
  output logic [31:0] instr_addr_out,
  output logic        instr_valid
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [31:0]   pc_d;
  logic [31:0]   rsp_pc_d;
  logic [CW-1:0] outstanding_d;
  logic [CW-1:0] drop_cnt_d;

  logic          req_fire;
  logic          rsp_fire;
  logic          rsp_accept;
  logic [CW:0]   credit_used;

  fetch_entry_t  rsp_entry;
  fetch_entry_t  fifo_dout;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic          out_en;
  logic          bypass;
  logic          out_valid_d;
  logic [31:0]   out_instr_d;
  logic [31:0]   out_addr_d;

  // Requests are held back while in reset so the channel is idle asynchronously.
  assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = rst_n && !redirect && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire   = imem_rsp_valid && (outstanding != '0);
  assign rsp_accept = rsp_fire && (drop_cnt == '0) && !redirect;
  assign rsp_entry  = '{addr: rsp_pc, instr: imem_rsp_data};

  assign out_en    = !stall || redirect;
  assign fifo_pop  = !stall && !redirect && !fifo_empty;
  assign bypass    = !stall && !redirect && fifo_empty && rsp_accept;
  assign fifo_push = rsp_accept && !bypass;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .din   (rsp_entry),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    pc_d          = pc;
    rsp_pc_d      = rsp_pc;
    outstanding_d = outstanding;
    drop_cnt_d    = drop_cnt;
    if (redirect) begin
      pc_d          = word_align(redirect_pc);
      rsp_pc_d      = word_align(redirect_pc);
      outstanding_d = outstanding - CW'(rsp_fire);
      // Every response still in flight is stale, including ones already marked for drop.
      drop_cnt_d    = outstanding - CW'(rsp_fire);
    end else begin
      if (req_fire) pc_d = pc + 32'd4;
      outstanding_d = outstanding + CW'(req_fire) - CW'(rsp_fire);
      if (rsp_fire && (drop_cnt != '0)) drop_cnt_d = drop_cnt - CW'(1);
      if (rsp_accept) rsp_pc_d = rsp_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      pc          <= pc_d;
      rsp_pc      <= rsp_pc_d;
      outstanding <= outstanding_d;
      drop_cnt    <= drop_cnt_d;
    end
  end

  always_comb begin
    out_valid_d = 1'b0;
    out_instr_d = NOP_INSTR;
    out_addr_d  = instr_addr_out;
    if (!redirect) begin
      if (!fifo_empty) begin
        out_valid_d = 1'b1;
        out_instr_d = fifo_dout.instr;
        out_addr_d  = fifo_dout.addr;
      end else if (rsp_accept) begin
        out_valid_d = 1'b1;
        out_instr_d = imem_rsp_data;
        out_addr_d  = rsp_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid    <= 1'b0;
      instr_out      <= NOP_INSTR;
      instr_addr_out <= '0;
    end else if (out_en) begin
      instr_valid    <= out_valid_d;
      instr_out      <= out_instr_d;
      instr_addr_out <= out_addr_d;
    end
  end

  a_rsp_has_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (outstanding == '0)));

endmodule

// File: tb/tb_fetch.sv
// Random and directed stimulus for fetch against a transaction-level model of the decode stream.
module tb_fetch;
  import core_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] instr_addr_out;
  logic        instr_valid;

  fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr_out      (instr_out),
    .instr_addr_out (instr_addr_out),
    .instr_valid    (instr_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          buffered = 0;
  logic [31:0] m_pc, exp_next, key;
  logic [31:0] last_addr, last_instr;
  logic        last_valid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pc       = 32'h0;
    exp_next   = 32'h0;
    buffered   = 0;
    last_valid = 1'b0;
    last_addr  = 32'h0;
    last_instr = NOP_INSTR;
    memq.delete();
    epoch++;
  endtask

  // One clock: drive inputs, check the request channel, clock, then check decode outputs.
  task automatic tick(input logic st, input logic rd, input logic [31:0] rpc,
                      input int rdy_pct, input int rsp_pct);
    logic        acc, rsp, kept, exp_req;
    int          avail;
    logic [31:0] tgt;
    mreq_t       head;
    stall          = st;
    redirect       = rd;
    redirect_pc    = rpc;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    rsp = (memq.size() > 0) && (memq[0].due <= cyc) && ($urandom_range(99) < rsp_pct);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? (memq[0].addr ^ key) : $urandom;
    #1;
    exp_req = !rd && ((memq.size() + buffered) < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) chk("req_addr", imem_req_addr, m_pc);
    acc = imem_req_valid && imem_req_ready;
    @(posedge clk);
    #1;
    kept = 1'b0;
    if (rsp) begin
      head = memq.pop_front();
      kept = !rd && (head.epoch == epoch);
    end
    if (acc) begin
      memq.push_back('{addr: m_pc, epoch: epoch, due: cyc + 1});
      m_pc = m_pc + 32'd4;
    end
    if (rd) begin
      tgt        = {rpc[31:2], 2'b00};
      epoch++;
      m_pc       = tgt;
      exp_next   = tgt;
      buffered   = 0;
      last_valid = 1'b0;
      last_instr = NOP_INSTR;
    end else begin
      avail = buffered + (kept ? 1 : 0);
      if (!st) begin
        if (avail > 0) begin
          last_valid = 1'b1;
          last_addr  = exp_next;
          last_instr = exp_next ^ key;
          exp_next   = exp_next + 32'd4;
          buffered   = avail - 1;
        end else begin
          last_valid = 1'b0;
          last_instr = NOP_INSTR;
          buffered   = 0;
        end
      end else begin
        buffered = avail;
      end
    end
    cyc++;
    chk("instr_valid", 32'(instr_valid), 32'(last_valid));
    chk("instr_out", instr_out, last_instr);
    chk("instr_addr_out", instr_addr_out, last_addr);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_instr"}, instr_out, NOP_INSTR);
    chk({tag, "_addr"}, instr_addr_out, 32'h0);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
  endtask

  // Reset asserted away from the clock edge; outputs must clear before any edge.
  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    stall          = 1'b0;
    redirect       = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    key = 32'h0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Zero-wait memory returning its address as data.
    tick(1'b0, 1'b0, 32'h0, 100, 100);
    chk("first_valid_c1", 32'(instr_valid), 32'h0);
    tick(1'b0, 1'b0, 32'h0, 100, 100);
    chk("first_valid_c2", 32'(instr_valid), 32'h1);
    chk("first_addr", instr_addr_out, 32'h0);
    repeat (8) tick(1'b0, 1'b0, 32'h0, 100, 100);

    // Stall at steady stream, then release.
    repeat (5) tick(1'b1, 1'b0, 32'h0, 100, 100);
    chk("stall_req_blocked", 32'(imem_req_valid), 32'h0);
    repeat (6) tick(1'b0, 1'b0, 32'h0, 100, 100);

    // Redirect while two requests are outstanding.
    guard = 0;
    while (memq.size() < 2 && guard < 20) begin
      tick(1'b0, 1'b0, 32'h0, 100, 0);
      guard++;
    end
    chk("two_outstanding", 32'(memq.size()), 32'd2);
    tick(1'b0, 1'b1, 32'h100, 100, 100);
    guard = 0;
    while (!instr_valid && guard < 20) begin
      tick(1'b0, 1'b0, 32'h0, 100, 100);
      guard++;
    end
    chk("redir_first_addr", instr_addr_out, 32'h100);
    repeat (4) tick(1'b0, 1'b0, 32'h0, 100, 100);

    // Redirect under stall with a full buffer.
    repeat (6) tick(1'b1, 1'b0, 32'h0, 100, 100);
    tick(1'b1, 1'b1, 32'h100, 100, 100);
    chk("redir_stall_valid", 32'(instr_valid), 32'h0);
    chk("redir_stall_instr", instr_out, NOP_INSTR);
    chk("redir_stall_req_addr", imem_req_addr, 32'h100);
    repeat (4) tick(1'b0, 1'b0, 32'h0, 100, 100);

    // Memory not ready for ten cycles.
    repeat (10) tick(1'b0, 1'b0, 32'h0, 0, 100);
    repeat (5) tick(1'b0, 1'b0, 32'h0, 100, 100);

    // PC wrap at the top of the address space; low bits of the target are ignored.
    tick(1'b0, 1'b1, 32'hFFFF_FFFE, 100, 100);
    tick(1'b0, 1'b0, 32'h0, 100, 100);
    chk("wrap_req_addr", imem_req_addr, 32'h0);
    repeat (5) tick(1'b0, 1'b0, 32'h0, 100, 100);

    // Reset mid-stream with traffic in flight.
    repeat (3) tick(1'b0, 1'b0, 32'h0, 100, 0);
    pulse_reset("midreset");
    key = $urandom;
    repeat (4) tick(1'b0, 1'b0, 32'h0, 100, 100);

    // Random traffic, stalls and redirects.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(99) < 25), ($urandom_range(99) < 4), $urandom,
           $urandom_range(40, 100), $urandom_range(40, 100));
    end
    stall = 1'b0;
    redirect = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
